// File: rtl/f_pkg.sv
// Shared types and constants for the f self-check sequencer.
package f_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    ONE   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NVEC  = 8;
  localparam int VEC_W = 3;
  localparam int CNT_W = 4;

  localparam logic [NVEC-1:0]  F_GOLDEN = 8'hAC;
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NVEC - 1);

endpackage

// File: rtl/f.sv
// The 3-input function under self-check: S = (~A|C) & (A|B) & (B|C).
module f (
  output logic S,
  input  logic A,
  input  logic B,
  input  logic C
);

  assign S = (~A | C) & (A | B) & (B | C);

endmodule

// File: rtl/f_sweep_ctrl.sv
// Shares one f instance between an 8-vector truth-table sweep and a
// single-vector evaluate request; all outputs are registered.
module f_sweep_ctrl
  import f_pkg::*;
#(
  parameter int unsigned     SETTLE   = 1,
  parameter logic [NVEC-1:0] EXPECTED = F_GOLDEN
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             req_i,
  input  logic [VEC_W-1:0] req_vec_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             busy_o,
  output logic             ack_o,
  output logic             rsp_s_o,
  output logic [NVEC-1:0]  table_o,
  output logic             done_o,
  output logic             pass_o
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [NVEC-1:0]   table_q, table_d;
  logic              rsp_s_q, rsp_s_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              s;

  f u_f (
    .S (s),
    .A (vec_q[2]),
    .B (vec_q[1]),
    .C (vec_q[0])
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    table_d = table_q;
    rsp_s_d = rsp_s_q;
    pass_d  = pass_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        vec_d = '0;
        if (start_i) begin
          state_d = SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          pass_d  = 1'b0;
        end else if (req_i) begin
          state_d = ONE;
          vec_d   = req_vec_i;
          cnt_d   = '0;
        end
      end

      SWEEP: begin
        // Abort wins over a same-cycle sample, so that bit is never written.
        if (abort_i) begin
          state_d = IDLE;
          pass_d  = 1'b0;
          vec_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_C) begin
          table_d[idx_q] = s;
          cnt_d          = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + VEC_W'(1);
            vec_d = idx_q + VEC_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ONE: begin
        if (cnt_q == SETTLE_C) begin
          rsp_s_d = s;
          ack_d   = 1'b1;
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        done_d  = 1'b1;
        pass_d  = (table_q == EXPECTED);
        state_d = IDLE;
        vec_d   = '0;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      rsp_s_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      rsp_s_q <= rsp_s_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign rsp_s_o = rsp_s_q;
  assign table_o = table_q;
  assign done_o  = done_q;
  assign pass_o  = pass_q;

endmodule

// File: tb/tb_f_sweep_ctrl.sv
// Scoreboard bench for f_sweep_ctrl: stimulus pushes expected sweep/eval
// results, a negedge monitor pops them whenever done or ack pulses.
module tb_f_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start2, abort, req;
  logic [2:0] req_vec;

  logic [2:0] vec, vec2;
  logic       busy, ack, rsp_s, done, pass;
  logic       busy2, ack2, rsp_s2, done2, pass2;
  logic [7:0] tbl, tbl2;

  f_sweep_ctrl #(.SETTLE(1), .EXPECTED(8'hAC)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .req_i(req), .req_vec_i(req_vec), .vec_o(vec), .busy_o(busy),
    .ack_o(ack), .rsp_s_o(rsp_s), .table_o(tbl), .done_o(done), .pass_o(pass)
  );

  f_sweep_ctrl #(.SETTLE(1), .EXPECTED(8'hFF)) dut_ff (
    .clk_i(clk), .reset_i(reset), .start_i(start2), .abort_i(1'b0),
    .req_i(1'b0), .req_vec_i(3'b000), .vec_o(vec2), .busy_o(busy2),
    .ack_o(ack2), .rsp_s_o(rsp_s2), .table_o(tbl2), .done_o(done2), .pass_o(pass2)
  );

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
  } sweep_exp_t;

  sweep_exp_t done_q[$];
  sweep_exp_t done2_q[$];
  logic       ack_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every done/ack pulse against the scoreboard queues.
  initial begin
    sweep_exp_t e;
    logic       r;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          e = done_q.pop_front();
          check("sweep_table", tbl, e.tbl);
          check("sweep_pass", pass, e.pass);
        end
      end
      if (done2) begin
        check("done2_expected", done2_q.size() > 0, 1);
        if (done2_q.size() > 0) begin
          e = done2_q.pop_front();
          check("sweep2_table", tbl2, e.tbl);
          check("sweep2_pass", pass2, e.pass);
        end
      end
      if (ack) begin
        check("ack_expected", ack_q.size() > 0, 1);
        if (ack_q.size() > 0) begin
          r = ack_q.pop_front();
          check("eval_rsp_s", rsp_s, r);
        end
      end
    end
  end

  initial begin
    int cnt;
    int early;
    bit seen;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
    req = 1'b0; req_vec = 3'b000;

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_rsp_s", rsp_s, 0);
    check("rst_table", tbl, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst2_table", tbl2, 0);

    // Full sweep: each vector held 2 cycles, done after edge 17
    start = 1'b1;
    done_q.push_back('{tbl: 8'hAC, pass: 1'b1});
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("t1_vec_step", vec, i / 2);
      check("t1_busy", busy, 1);
      check("t1_no_early_done", done, 0);
      tick();
    end
    check("t1_busy_in_done", busy, 1);
    tick();
    check("t1_done_latency", done, 1);
    check("t1_busy_after", busy, 0);
    check("t1_vec_idle", vec, 0);
    tick();
    check("t1_done_one_cycle", done, 0);
    check("t1_pass_held", pass, 1);

    // Wrong golden mask: table still AC, pass 0, single done pulse
    start2 = 1'b1;
    done2_q.push_back('{tbl: 8'hAC, pass: 1'b0});
    tick();
    start2 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done2) cnt++;
      tick();
    end
    check("t2_done_pulses", cnt, 1);
    check("t2_pass", pass2, 0);
    check("t2_table", tbl2, 8'hAC);

    // Single eval 101 -> 1 with latency 2
    req = 1'b1; req_vec = 3'b101;
    ack_q.push_back(1'b1);
    tick();
    check("t3_vec_held", vec, 3'b101);
    check("t3_busy", busy, 1);
    check("t3_ack_lat0", ack, 0);
    tick();
    check("t3_ack_lat1", ack, 0);
    tick();
    check("t3_ack_lat2", ack, 1);
    req = 1'b0;
    tick();
    check("t3_ack_one_cycle", ack, 0);
    check("t3_rsp_hold", rsp_s, 1);

    // Single eval 100 -> 0
    req = 1'b1; req_vec = 3'b100;
    ack_q.push_back(1'b0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ack) seen = 1;
    end
    check("t3b_ack_seen", seen, 1);
    req = 1'b0;
    tick();
    check("t3b_rsp_hold", rsp_s, 0);

    // start and req together: sweep first, req served afterwards
    start = 1'b1; req = 1'b1; req_vec = 3'b010;
    done_q.push_back('{tbl: 8'hAC, pass: 1'b1});
    ack_q.push_back(1'b1);
    tick();
    start = 1'b0;
    seen = 0; early = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ack) early++;
      if (done) seen = 1;
      if (!seen) tick();
    end
    check("t4_done_seen", seen, 1);
    check("t4_no_ack_in_sweep", early, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ack) seen = 1;
    end
    check("t4_ack_seen", seen, 1);
    req = 1'b0;
    tick();

    // Abort at cycle 7 (idx=3, cnt=0): bits 0..2 kept -> 8'h04
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("t5_vec_idx3", vec, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_vec", vec, 0);
    check("t5_table", tbl, 8'h04);
    check("t5_pass", pass, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) cnt++;
      tick();
    end
    check("t5_no_done", cnt, 0);

    // Abort on the sample cycle of idx=3: that sample is discarded
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("t5b_vec_idx3", vec, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5b_table", tbl, 8'h04);
    check("t5b_busy", busy, 0);

    // Reset mid-sweep at idx=5, then a clean sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("t6_vec_idx5", vec, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_vec", vec, 0);
    check("t6_busy", busy, 0);
    check("t6_table", tbl, 0);
    check("t6_done", done, 0);
    check("t6_pass", pass, 0);
    check("t6_ack", ack, 0);
    start = 1'b1;
    done_q.push_back('{tbl: 8'hAC, pass: 1'b1});
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done) seen = 1;
    end
    check("t6_done_seen", seen, 1);

    repeat (3) tick();
    check("sb_done_empty", done_q.size(), 0);
    check("sb_done2_empty", done2_q.size(), 0);
    check("sb_ack_empty", ack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
